satd_control: RTL and testbench



---
 rtl/satd_ctrl_pkg.sv | 38 +++
 rtl/satd_ctrl_decode.sv | 35 +++
 rtl/satd_control.sv | 54 +++++
 tb/tb_satd_control.sv | 135 +++++++++++++
 4 files changed

// File: rtl/satd_ctrl_pkg.sv
// Shared encodings for the SATD sequencer: phase codes, strobe bit positions
// and the last sub-cycle index of a phase.
package satd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOAD      = 2'b01,
    ST_TRANSFORM = 2'b10,
    ST_SUM       = 2'b11
  } state_t;

  localparam int OUT_W = 10;

  // out_signal bit positions
  localparam int B_LOAD_EN   = 0;
  localparam int B_BUF_CLR   = 1;
  localparam int B_STAGE1_EN = 2;
  localparam int B_STAGE2_EN = 3;
  localparam int B_SEL_LO    = 4;
  localparam int B_SEL_HI    = 5;
  localparam int B_ABS_EN    = 6;
  localparam int B_ACC_CLR   = 7;
  localparam int B_ACC_EN    = 8;
  localparam int B_DONE      = 9;

  localparam logic [2:0] COUNT_LAST = 3'd7;

  // Phase that follows st once its last sub-cycle completes.
  function automatic state_t next_phase(input state_t st);
    case (st)
      ST_LOAD:      next_phase = ST_TRANSFORM;
      ST_TRANSFORM: next_phase = ST_SUM;
      ST_SUM:       next_phase = ST_LOAD;
      default:      next_phase = ST_LOAD;
    endcase
  endfunction

endpackage

// File: rtl/satd_ctrl_decode.sv
// Pure combinational decode of (phase, sub-cycle) into datapath strobes.
// Kept standalone so datapath benches can drive it directly.
module satd_ctrl_decode
  import satd_ctrl_pkg::*;
(
  input  logic [1:0]       state,
  input  logic [2:0]       count,
  output logic [OUT_W-1:0] out_signal
);

  // Strobe map; everything defaults low, which also covers IDLE.
  always_comb begin
    out_signal = '0;
    case (state)
      ST_LOAD: begin
        out_signal[B_LOAD_EN] = 1'b1;
        out_signal[B_BUF_CLR] = (count == 3'd0);
      end
      ST_TRANSFORM: begin
        out_signal[B_STAGE1_EN] = (count < 3'd4);
        out_signal[B_STAGE2_EN] = (count >= 3'd4);
        out_signal[B_SEL_LO]    = count[0];
        out_signal[B_SEL_HI]    = count[1];
      end
      ST_SUM: begin
        out_signal[B_ABS_EN]  = 1'b1;
        out_signal[B_ACC_CLR] = (count == 3'd0);
        out_signal[B_ACC_EN]  = 1'b1;
        out_signal[B_DONE]    = (count == COUNT_LAST);
      end
      default: out_signal = '0;
    endcase
  end

endmodule

// File: rtl/satd_control.sv
// Free-running LOAD/TRANSFORM/SUM sequencer, 8 clocks per phase. IDLE is only
// seen for the single cycle after reset release.
module satd_control
  import satd_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic [OUT_W-1:0] out_signal,
  output logic [1:0]       state,
  output logic [2:0]       count
);

  state_t     st_q, st_n;
  logic [2:0] cnt_q, cnt_n;

  // Phase and sub-cycle registers, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_n;
      cnt_q <= cnt_n;
    end
  end

  // Next phase/count: IDLE hands over to LOAD at count 0; active phases
  // count 0..7 and the 3-bit counter wraps on its own at the phase change.
  always_comb begin
    st_n  = st_q;
    cnt_n = cnt_q;
    case (st_q)
      ST_IDLE: begin
        st_n  = ST_LOAD;
        cnt_n = '0;
      end
      default: begin
        cnt_n = cnt_q + 3'd1;
        if (cnt_q == COUNT_LAST) st_n = next_phase(st_q);
      end
    endcase
  end

  // Outputs: registered phase/count exposed directly, strobes decoded from them.
  assign state = st_q;
  assign count = cnt_q;

  satd_ctrl_decode u_decode (
    .state      (st_q),
    .count      (cnt_q),
    .out_signal (out_signal)
  );

endmodule

// File: tb/tb_satd_control.sv
// Directed bench for satd_control: per-edge vector table for the first 30
// edges, done-pulse positions over 50 edges, and an asynchronous mid-phase reset.
module tb_satd_control;

  logic       clk;
  logic       reset;
  logic [9:0] out_signal;
  logic [1:0] state;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] st;
    logic [2:0] cnt;
    logic [9:0] out;
  } vec_t;

  vec_t vecs [1:30];

  satd_control dut (
    .clk        (clk),
    .reset      (reset),
    .out_signal (out_signal),
    .state      (state),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the bench is purely clock-counted, this only guards a stall.
  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, expected finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int e, input logic [1:0] s, input logic [2:0] c, input logic [9:0] o);
    vecs[e].st  = s;
    vecs[e].cnt = c;
    vecs[e].out = o;
  endtask

  // Check state/count/out_signal against table entries 1..n, one edge each.
  task automatic run_table(input string tag, input int n);
    for (int e = 1; e <= n; e++) begin
      @(posedge clk); #1;
      chk($sformatf("%s e%0d state", tag, e), {8'd0, state}, {8'd0, vecs[e].st});
      chk($sformatf("%s e%0d count", tag, e), {7'd0, count}, {7'd0, vecs[e].cnt});
      chk($sformatf("%s e%0d out", tag, e), out_signal, vecs[e].out);
    end
  endtask

  task automatic reset_phase(input string tag);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s rst%0d state", tag, i), {8'd0, state}, 10'd0);
      chk($sformatf("%s rst%0d count", tag, i), {7'd0, count}, 10'd0);
      chk($sformatf("%s rst%0d out", tag, i), out_signal, 10'h000);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int done_edges;
    // LOAD edges 1..8
    set_vec(1, 2'b01, 3'd0, 10'h003);
    for (int e = 2; e <= 8; e++) set_vec(e, 2'b01, 3'(e - 1), 10'h001);
    // TRANSFORM edges 9..16
    set_vec(9,  2'b10, 3'd0, 10'h004);
    set_vec(10, 2'b10, 3'd1, 10'h014);
    set_vec(11, 2'b10, 3'd2, 10'h024);
    set_vec(12, 2'b10, 3'd3, 10'h034);
    set_vec(13, 2'b10, 3'd4, 10'h008);
    set_vec(14, 2'b10, 3'd5, 10'h018);
    set_vec(15, 2'b10, 3'd6, 10'h028);
    set_vec(16, 2'b10, 3'd7, 10'h038);
    // SUM edges 17..24
    set_vec(17, 2'b11, 3'd0, 10'h1C0);
    for (int e = 18; e <= 23; e++) set_vec(e, 2'b11, 3'(e - 17), 10'h140);
    set_vec(24, 2'b11, 3'd7, 10'h340);
    // Back to LOAD edges 25..30
    set_vec(25, 2'b01, 3'd0, 10'h003);
    for (int e = 26; e <= 30; e++) set_vec(e, 2'b01, 3'(e - 25), 10'h001);

    // Scenario 1: reset held 3 edges, then 30 edges of sequence.
    reset_phase("s1");
    run_table("s1", 30);

    // Scenario 2: done pulses over 50 edges from a fresh reset.
    reset_phase("s2");
    done_edges = 0;
    for (int e = 1; e <= 50; e++) begin
      @(posedge clk); #1;
      if (out_signal[9]) begin
        done_edges++;
        chk($sformatf("s2 done at e%0d expected edge", e), 10'(e),
            (done_edges == 1) ? 10'd24 : 10'd48);
      end
      if (e == 24 || e == 48)
        chk($sformatf("s2 done e%0d", e), {9'd0, out_signal[9]}, 10'd1);
      if (e > 1 && state == 2'b00)
        chk($sformatf("s2 idle reappeared e%0d", e), {8'd0, state}, 10'd1);
    end
    chk("s2 done count", 10'(done_edges), 10'd2);

    // Scenario 3: async reset mid-TRANSFORM at count 5, between edges.
    reset_phase("s3");
    run_table("s3", 14);
    #2;
    reset = 1'b0;
    #1;
    chk("s3 async state", {8'd0, state}, 10'd0);
    chk("s3 async count", {7'd0, count}, 10'd0);
    chk("s3 async out", out_signal, 10'h000);
    reset_phase("s3b");
    run_table("s3r", 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
